// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package ifetch_pkg;

    localparam int DEPTH_DEF  = 256;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [DATA_W_DEF-1:0] NOP_INSTR = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

endpackage

// File: rtl/ifetch_if.sv
// Byte-wide program load handshake between the host and the fetch stage.
interface ifetch_if import ifetch_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;

    modport master (output load_valid, load_data, load_done, input load_ready);
    modport slave  (input load_valid, load_data, load_done, output load_ready);

endinterface

// File: rtl/ifetch_mem.sv
// Instruction RAM: one write port, one synchronous read port, contents never reset.
module ifetch_mem import ifetch_pkg::*; #(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program load, run/pause/halt control, registered fetch.
// Define IFETCH_STEP_EN to enable single-step while paused.
module instr_fetch import ifetch_pkg::*; #(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    ifetch_if.slave           host,
    input  logic              run,
    input  logic              step,
    input  logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] instruction,
    output logic              cpu_en,
    output logic [1:0]        state
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state_r, state_n;
    logic [ADDR_W:0]   ptr, ptr_n;
    logic [ADDR_W:0]   prog_len, prog_len_n;
    logic              ready_r;
    logic              accept;
    logic              step_fire;
    logic              fetch_ok;
    logic              vld_p1;
    logic [DATA_W-1:0] rdata_p1;

    always_comb begin
        state_n    = state_r;
        ptr_n      = ptr;
        prog_len_n = prog_len;
        accept     = 1'b0;
        step_fire  = 1'b0;
        case (state_r)
            IDLE: begin
                if (host.load_valid) begin
                    state_n = LOAD;
                    ptr_n   = '0;
                end else if (run && prog_len != '0) begin
                    state_n = RUN;
                end
            end
            LOAD: begin
                accept = host.load_valid && ready_r;
                if (accept) begin
                    ptr_n = ptr + 1'b1;
                end
                // A byte accepted alongside load_done is part of the image.
                if (host.load_done) begin
                    state_n    = IDLE;
                    prog_len_n = ptr_n;
                end
            end
            RUN: begin
                if (!run) begin
                    state_n = IDLE;
                end else if ({1'b0, PC} >= prog_len) begin
                    state_n = HALT;
                end
            end
            HALT: begin
                if (host.load_valid) begin
                    state_n = LOAD;
                    ptr_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef IFETCH_STEP_EN
        step_fire = (state_r == IDLE) && (state_n == IDLE) && step && (prog_len != '0);
`endif
    end

`ifndef IFETCH_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    // Fetch runs regardless of cpu_en so the instruction is ready on resume.
    assign fetch_ok = ({1'b0, PC} < prog_len) && (state_n != HALT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r  <= IDLE;
            ptr      <= '0;
            prog_len <= '0;
            ready_r  <= 1'b0;
            cpu_en   <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            state_r  <= state_n;
            ptr      <= ptr_n;
            prog_len <= prog_len_n;
            ready_r  <= (state_n == LOAD) && (ptr_n < DEPTH_L);
            cpu_en   <= (state_n == RUN) || step_fire;
            vld_p1   <= fetch_ok;
        end
    end

    // ---- stage p1: RAM read data, NOP substituted when fetch is not valid ----
    ifetch_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (CLK),
        .we    (accept && !RESET),
        .waddr (ptr[ADDR_W-1:0]),
        .wdata (host.load_data),
        .raddr (PC),
        .rdata (rdata_p1)
    );

    assign instruction     = vld_p1 ? rdata_p1 : DATA_W'(NOP_INSTR);
    assign host.load_ready = ready_r;
    assign state           = state_r;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the 8-bit single-cycle datapath. It holds the program in a 256×8 instruction memory filled through a byte-wide load handshake. It returns the instruction addressed by the datapath's `PC` and gates the datapath's advance with a clock-enable. Run, pause and single-step are controlled by board-level inputs.

## Interface
- `DEPTH`, 256: instruction memory words; must be ≤ 2^`ADDR_W`.
- `ADDR_W`, 8: address width; matches datapath `PC`.
- `DATA_W`, 8: instruction width.

- `CLK`  in  1  single clock; all state changes on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  host presents `load_data` this cycle.
- `load_data`  in  DATA_W  instruction byte to store.
- `load_ready`  out  1  block accepts a byte this cycle.
- `load_done`  in  1  one-cycle pulse; end of program image.
- `run`  in  1  level; 1 = execute continuously.
- `step`  in  1  one-cycle pulse; execute one instruction while paused.
- `PC`  in  ADDR_W  fetch address from the datapath.
- `instruction`  out  DATA_W  registered instruction for the datapath.
- `cpu_en`  out  1  datapath may commit its state this cycle.
- `state`  out  2  FSM state, for debug LEDs.

## Operation
- States (from package): IDLE=0, LOAD=1, RUN=2, HALT=3.
- Reset values:
  - `state`=IDLE, `load_ready`=0, `cpu_en`=0, `instruction`=8'h00 (NOP).
  - Load pointer `ptr`=0, `prog_len`=0.
  - Memory contents are not cleared.
- IDLE:
  - `load_valid` → LOAD, with `ptr` cleared to 0. This has priority over `run`.
  - `run`=1 with `prog_len`≠0 → RUN.
  - `step` with `prog_len`≠0 → `cpu_en`=1 for exactly one cycle. Stays in IDLE.
- LOAD:
  - `load_ready`=1 while `ptr`<DEPTH.
  - On `load_valid && load_ready`: mem[`ptr`]←`load_data`, then `ptr`+1.
  - `ptr` is ADDR_W+1 bits wide and never wraps. At `ptr`=DEPTH, `load_ready`=0 and further bytes are ignored.
  - `load_done` → IDLE with `prog_len`←`ptr`. If a byte is accepted in the same cycle, it is counted (`prog_len`=`ptr`+1).
  - `run` and `step` are ignored in LOAD.
- RUN:
  - `cpu_en`=1 every cycle.
  - `run`=0 → IDLE (pause). `cpu_en` drops in the same cycle as the transition.
  - `PC`≥`prog_len` → HALT.
- HALT:
  - `cpu_en`=0 and `instruction` is forced to NOP.
  - Left only by `RESET`, or by `load_valid` (→ LOAD with `ptr`=0).
- Fetch:
  - Every cycle, `instruction`←mem[`PC`] when `PC`<`prog_len`, otherwise NOP.
  - Fetch is independent of `cpu_en`, so the instruction is already valid when execution resumes.

## Timing
- Fetch latency is 1 cycle: `PC` sampled at edge n appears on `instruction` after edge n.
- Load throughput is 1 byte/cycle. `load_ready` is a registered output, updated one cycle after a state change.
- `cpu_en` is registered.
  - It rises the cycle after entry to RUN.
  - A `step` pulse at edge n gives `cpu_en`=1 for the cycle after edge n only.
  - Back-to-back `step` pulses give back-to-back enables.
- RESET asserted mid-LOAD or mid-RUN overrides all inputs in that cycle. Bytes already written remain in memory.

## Configuration
- `IFETCH_STEP_EN` defined: single-step behaves as described above.
- `IFETCH_STEP_EN` undefined:
  - The `step` port remains but is ignored.
  - The datapath can only advance in RUN.
  - No step logic is synthesised.

## Structure
- Package `ifetch_pkg` holds:
  - the state enum/localparams IDLE/LOAD/RUN/HALT;
  - `NOP_INSTR`=8'h00;
  - the default widths.
- Sub-module `ifetch_mem`: DEPTH×DATA_W RAM with one write port, one synchronous read port and no reset. It provides the registered `instruction`, with NOP substitution in the parent.
- FSM, pointer and `prog_len` registers live in `instr_fetch`.

## Test plan
- Load and run: load 4 bytes 8'h11,8'h22,8'h33,8'h44, pulse `load_done`, set `run`=1, drive `PC`=0..3.
  - `prog_len`=4 and `cpu_en`=1.
  - `instruction` shows 11,22,33,44, each one cycle after its `PC`.
  - `PC`=4 → `state`=HALT, `cpu_en`=0, `instruction`=00.
- Load overflow: stream 257 bytes with `load_valid` held.
  - `load_ready` drops after 256 accepts.
  - `load_done` sets `prog_len`=256; byte 257 is not written.
- Simultaneous write and done: `load_valid` and `load_done` in the same cycle after 2 accepts → `prog_len`=3.
- Pause/step (macro defined): in RUN, drop `run` → IDLE, `cpu_en`=0; then one `step` pulse → `cpu_en`=1 for exactly one cycle. With the macro undefined, the same `step` pulse → `cpu_en` stays 0.
- Reset mid-RUN: assert `RESET` for 1 cycle at `PC`=2 → IDLE, `cpu_en`=0, `instruction`=00, `prog_len`=0. `run`=1 afterwards does not leave IDLE.
- Reload from HALT: `load_valid` in HALT → LOAD with `ptr`=0; the new bytes overwrite from address 0.
